// File: rtl/memxfer_pkg.sv
// Constants and types shared across the memory-to-memory transfer datapath.
// The transfer engine and the result drain both size themselves from these.
package memxfer_pkg;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = $clog2(DEPTH);

   typedef enum logic {
      COLLECT = 1'b0,
      FLUSH   = 1'b1
   } drain_state_t;

endpackage

// File: rtl/drain_regfile.sv
// Frame storage for the result drain: synchronous write, combinational read.
// Contents are never cleared; the control side tracks which entries are live.
module drain_regfile #(
   parameter int DATA_W = memxfer_pkg::DATA_W,
   parameter int DEPTH  = memxfer_pkg::DEPTH,
   parameter int ADDR_W = memxfer_pkg::ADDR_W
) (
   input  logic              Clk,
   input  logic              We,
   input  logic [ADDR_W-1:0] WAddr,
   input  logic [DATA_W-1:0] WData,
   input  logic [ADDR_W-1:0] RAddr,
   output logic [DATA_W-1:0] RData
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge Clk) begin
      if (We) begin
         mem[WAddr] <= WData;
      end
   end

   assign RData = mem[RAddr];

endmodule

// File: rtl/memb_result_drain.sv
// Collects memory-B result words into fixed frames, checksums each frame and
// replays it in arrival order to a consumer that may stall.
module memb_result_drain #(
   parameter int DATA_W = memxfer_pkg::DATA_W,
   parameter int DEPTH  = memxfer_pkg::DEPTH,
   parameter int ADDR_W = memxfer_pkg::ADDR_W,
   parameter int SUM_W  = DATA_W + ADDR_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              InValid,
   input  logic [DATA_W-1:0] InData,
   output logic              InReady,
   output logic              OutValid,
   output logic [DATA_W-1:0] OutData,
   input  logic              OutReady,
   output logic              FrameDone,
   output logic [SUM_W-1:0]  FrameSum,
   output logic              Overrun
);

   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

   memxfer_pkg::drain_state_t state_q;
   memxfer_pkg::drain_state_t state_d;

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic [SUM_W-1:0]  acc;
   logic [SUM_W-1:0]  frame_sum;
   logic              frame_done;
   logic              overrun;

   logic in_ready;
   logic out_valid;
   logic accept;
   logic pop;
   logic last_accept;

   function automatic logic [SUM_W-1:0] zext(input logic [DATA_W-1:0] d);
      return {{(SUM_W-DATA_W){1'b0}}, d};
   endfunction

   assign accept      = InValid && in_ready;
   assign pop         = out_valid && OutReady;
   assign last_accept = accept && (count == LAST_CNT);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= memxfer_pkg::COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   // COLLECT only accepts, FLUSH only pops, so push and pop never overlap
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         memxfer_pkg::COLLECT: begin
            in_ready = 1'b1;
            if (InValid && (count == LAST_CNT)) begin
               state_d = memxfer_pkg::FLUSH;
            end
         end
         memxfer_pkg::FLUSH: begin
            out_valid = (count != '0);
            if (out_valid && OutReady && (count == ONE_CNT)) begin
               state_d = memxfer_pkg::COLLECT;
            end
         end
         default: state_d = memxfer_pkg::COLLECT;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         acc        <= '0;
         frame_sum  <= '0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_done <= last_accept;
         if (InValid && !in_ready) begin
            overrun <= 1'b1;
         end
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
            if (last_accept) begin
               frame_sum <= acc + zext(InData);
               acc       <= '0;
            end else begin
               acc <= acc + zext(InData);
            end
         end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
         end
      end
   end

   drain_regfile #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .Clk   (Clk),
      .We    (accept),
      .WAddr (wr_ptr),
      .WData (InData),
      .RAddr (rd_ptr),
      .RData (OutData)
   );

   assign InReady   = in_ready;
   assign OutValid  = out_valid;
   assign FrameDone = frame_done;
   assign FrameSum  = frame_sum;
   assign Overrun   = overrun;

endmodule

// File: tb/tb_memb_result_drain.sv
// Directed-vector bench for memb_result_drain with hand-computed frame sums.
module tb_memb_result_drain;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       InValid = 1'b0;
   logic [7:0] InData = 8'd0;
   logic       InReady;
   logic       OutValid;
   logic [7:0] OutData;
   logic       OutReady = 1'b0;
   logic       FrameDone;
   logic [9:0] FrameSum;
   logic       Overrun;

   int n_vec  = 0;
   int n_miss = 0;
   int fd_cnt = 0;

   memb_result_drain dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .InValid   (InValid),
      .InData    (InData),
      .InReady   (InReady),
      .OutValid  (OutValid),
      .OutData   (OutData),
      .OutReady  (OutReady),
      .FrameDone (FrameDone),
      .FrameSum  (FrameSum),
      .Overrun   (Overrun)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      if (FrameDone) fd_cnt <= fd_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      int t = 0;
      while (!InReady && t < 50) begin
         tick();
         t++;
      end
      check("push_ready", 32'(InReady), 32'd1);
      InValid = 1'b1;
      InData  = d;
      tick();
      InValid = 1'b0;
   endtask

   task automatic pop_expect(input logic [7:0] exp);
      int t = 0;
      while (!OutValid && t < 50) begin
         tick();
         t++;
      end
      check("pop_valid", 32'(OutValid), 32'd1);
      check("pop_data", 32'(OutData), 32'(exp));
      OutReady = 1'b1;
      tick();
      OutReady = 1'b0;
   endtask

   task automatic frame_end_check(input logic [9:0] sum, input logic [7:0] first);
      check("frame_done", 32'(FrameDone), 32'd1);
      check("frame_sum", 32'(FrameSum), 32'(sum));
      check("first_valid", 32'(OutValid), 32'd1);
      check("first_data", 32'(OutData), 32'(first));
      check("flush_not_ready", 32'(InReady), 32'd0);
   endtask

   initial begin
      logic [7:0] bp [4];
      logic [3:0] pat;
      int         e;
      int         fd_base;

      // reset state
      #2;
      check("rst_in_ready", 32'(InReady), 32'd1);
      check("rst_out_valid", 32'(OutValid), 32'd0);
      check("rst_frame_done", 32'(FrameDone), 32'd0);
      check("rst_frame_sum", 32'(FrameSum), 32'd0);
      check("rst_overrun", 32'(Overrun), 32'd0);
      tick();
      tick();
      Reset = 1'b1;
      tick();

      // basic frame, back-to-back
      push(8'd37); push(8'd20); push(8'd57); push(8'd142);
      frame_end_check(10'd256, 8'd37);
      pop_expect(8'd37);
      check("done_one_cycle", 32'(FrameDone), 32'd0);
      pop_expect(8'd20); pop_expect(8'd57); pop_expect(8'd142);
      check("basic_ready_back", 32'(InReady), 32'd1);
      check("basic_empty", 32'(OutValid), 32'd0);

      // backpressure
      bp[0] = 8'd119; bp[1] = 8'd84; bp[2] = 8'd231; bp[3] = 8'd7;
      for (int i = 0; i < 4; i++) push(bp[i]);
      check("bp_sum", 32'(FrameSum), 32'd441);
      for (int i = 0; i < 5; i++) begin
         check("bp_stall_data", 32'(OutData), 32'd119);
         check("bp_stall_valid", 32'(OutValid), 32'd1);
         tick();
      end
      pat = 4'b0;
      e = 0;
      for (int i = 0; i < 5; i++) begin
         OutReady = (i != 1);
         check("bp_order", 32'(OutData), 32'(bp[e]));
         tick();
         if (i != 1) e++;
      end
      OutReady = 1'b0;
      check("bp_all_popped", 32'(e), 32'd4);
      check("bp_ready_back", 32'(InReady), 32'd1);
      check("bp_sum_hold", 32'(FrameSum), 32'd441);
      check("no_overrun_yet", 32'(Overrun), 32'd0);

      // overrun during flush
      push(8'd10); push(8'd20); push(8'd30); push(8'd40);
      check("ovr_sum", 32'(FrameSum), 32'd100);
      InValid = 1'b1;
      InData  = 8'd99;
      check("ovr_not_ready", 32'(InReady), 32'd0);
      tick();
      InValid = 1'b0;
      check("ovr_set", 32'(Overrun), 32'd1);
      pop_expect(8'd10); pop_expect(8'd20); pop_expect(8'd30); pop_expect(8'd40);
      push(8'd1); push(8'd1); push(8'd1); push(8'd1);
      frame_end_check(10'd4, 8'd1);
      for (int i = 0; i < 4; i++) pop_expect(8'd1);
      check("ovr_sticky", 32'(Overrun), 32'd1);

      // max sum, two frames, pointer wrap
      fd_base = fd_cnt;
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 4; i++) push(8'd255);
         frame_end_check(10'd1020, 8'd255);
         for (int i = 0; i < 4; i++) pop_expect(8'd255);
      end
      tick();
      check("max_done_pulses", 32'(fd_cnt - fd_base), 32'd2);

      // reset mid-frame
      push(8'd5); push(8'd6);
      Reset = 1'b0;
      #1;
      check("midrst_sum", 32'(FrameSum), 32'd0);
      check("midrst_overrun", 32'(Overrun), 32'd0);
      check("midrst_ready", 32'(InReady), 32'd1);
      tick();
      Reset = 1'b1;
      tick();
      push(8'd1); push(8'd2); push(8'd3); push(8'd4);
      frame_end_check(10'd10, 8'd1);
      pop_expect(8'd1); pop_expect(8'd2); pop_expect(8'd3); pop_expect(8'd4);
      check("midrst_overrun_clear", 32'(Overrun), 32'd0);

      // idle gaps between accepts
      bp[0] = 8'd37; bp[1] = 8'd20; bp[2] = 8'd57; bp[3] = 8'd142;
      for (int i = 0; i < 4; i++) begin
         push(bp[i]);
         if (i < 3) begin
            InData = 8'd200;
            for (int g = 0; g < 3; g++) tick();
            check("gap_no_done", 32'(FrameDone), 32'd0);
         end
      end
      frame_end_check(10'd256, 8'd37);
      for (int i = 0; i < 4; i++) pop_expect(bp[i]);
      check("gap_ready_back", 32'(InReady), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/memb_result_drain.md
# memb_result_drain

Downstream stage for the memory-to-memory transfer datapath. It accepts the 8-bit result words leaving memory B one per handshake and collects them into fixed 4-word frames. It computes the frame checksum, then replays the frame in arrival order on a valid/ready output port. It decouples the transfer engine from a consumer that may stall, and flags any word offered while it cannot accept.

## Interface
Parameters:
- DATA_W, 8, result word width (matches memory B data width)
- DEPTH, 4, words per frame (matches memory B entry count)
- ADDR_W, 2, log2(DEPTH); pointer width
- SUM_W, DATA_W+ADDR_W (10), checksum width; holds DEPTH*(2^DATA_W-1) without overflow

Ports:
- Clk  in  1  single clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-low; state cleared while 0
- InValid  in  1  upstream offers InData this cycle
- InData  in  DATA_W  result word from memory B (DataOutB)
- InReady  out  1  block accepts InData this cycle
- OutValid  out  1  OutData holds a frame word
- OutData  out  DATA_W  frame word, arrival order
- OutReady  in  1  consumer takes OutData this cycle
- FrameDone  out  1  one-cycle pulse: a full frame has been captured
- FrameSum  out  SUM_W  unsigned sum of the last completed frame
- Overrun  out  1  sticky: a word was offered while InReady=0

## Operation
- Two states: COLLECT, FLUSH. Reset enters COLLECT.
- COLLECT:
  - InReady=1, OutValid=0.
  - A word is accepted on InValid&&InReady. The accept writes buf[wr_ptr], increments wr_ptr and count, and adds the zero-extended InData to acc.
  - On the accept that makes count==DEPTH, the next state is FLUSH. On that same edge, FrameSum<=acc+InData, FrameDone<=1 and acc<=0.
- FLUSH:
  - InReady=0. OutValid=(count!=0). OutData=buf[rd_ptr], first-word fall-through with no register stage.
  - A pop on OutValid&&OutReady increments rd_ptr and decrements count.
  - The pop that empties the buffer returns the state to COLLECT. wr_ptr and rd_ptr are both 0 at that point, by natural wrap.
- Pointers are ADDR_W bits and wrap modulo DEPTH. count is ADDR_W+1 bits, range 0..DEPTH.
- Overrun is set on any cycle with InValid=1 and InReady=0. It is cleared only by reset. The offered word is dropped and does not touch acc.
- No simultaneous push and pop can occur, because the states are exclusive. An OutReady with OutValid=0 is ignored.
- FrameSum holds its value until the next frame completes.

## Timing
- Reset values: InReady=1, OutValid=0, OutData=buf[0] (contents don't-care, buffer not cleared), FrameDone=0, FrameSum=0, Overrun=0. State, pointers, count and acc are all 0.
- Reset mid-frame discards the partial frame and the partial acc immediately (asynchronously). Collection restarts at word 0 after release.
- Latency:
  - The 4th word is accepted at edge N. At N+1, FrameDone=1, FrameSum is valid and OutValid=1 with the first word.
  - With OutReady held high, the frame drains in DEPTH cycles. InReady returns to 1 in the cycle after the last pop.
- Minimum frame period with no stalls is 2*DEPTH cycles.
- FrameDone is high for exactly one cycle per frame.

## Structure
- Shared package memxfer_pkg holds:
  - the DATA_W, DEPTH and ADDR_W constants, shared with the transfer engine;
  - the drain_state_t enum {COLLECT, FLUSH}.
- Sub-module drain_regfile holds the DEPTH x DATA_W storage: synchronous write and combinational read, with ports Clk, We, WAddr, WData, RAddr, RData. It has no reset.
- The top level holds the FSM, pointers, count, accumulator and flags.

## Test plan
- Basic frame: push 37, 20, 57, 142 back-to-back, OutReady=1 -> FrameDone one cycle after the 4th accept, FrameSum=256, OutData 37, 20, 57, 142 on consecutive cycles, InReady high again after the 4th pop.
- Backpressure: push 119, 84, 231, 7; hold OutReady=0 for 5 cycles, then toggle it 1,0,1,1,1 -> OutData stable at 119 while stalled, order preserved, FrameSum=441, no word duplicated or lost.
- Overrun: during FLUSH drive InValid=1 with InData=99 -> InReady=0, Overrun=1 and stays 1, 99 never appears on OutData, next frame's FrameSum excludes 99.
- Max sum / wrap: two consecutive frames of 255 x4 -> FrameSum=1020 both times, pointers wrap to 0, FrameDone pulses exactly twice.
- Reset mid-operation: accept 2 words, assert Reset low for 1 cycle, then push 1, 2, 3, 4 -> FrameSum=10, output 1, 2, 3, 4, Overrun=0.
- Idle gaps: push 4 words with InValid low for 3 cycles between each -> same result as back-to-back, acc unaffected by non-valid cycles.
